// File: rtl/signal_gen_multichannel.sv
// Multichannel pulse generator: per-channel high/low phases and a period count.
// Optional SIGGEN_INVERT_EN adds a per-channel output polarity latched at start.
module signal_gen_multichannel #(
  parameter int NUM_CHANNELS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CHANNELS-1:0]    gen_start,
  input  logic [NUM_CHANNELS-1:0]    gen_stop,
  input  logic [NUM_CHANNELS*16-1:0] high_time,
  input  logic [NUM_CHANNELS*16-1:0] low_time,
  input  logic [NUM_CHANNELS*16-1:0] pulse_count,
`ifdef SIGGEN_INVERT_EN
  input  logic [NUM_CHANNELS-1:0]    gen_invert,
`endif
  output logic [NUM_CHANNELS-1:0]    gen_pin,
  output logic [NUM_CHANNELS-1:0]    gen_busy,
  output logic [NUM_CHANNELS-1:0]    gen_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    state_t      state, state_n;
    logic [15:0] phase, phase_n;
    logic [15:0] periods, periods_n;
    logic [15:0] sh_high, sh_high_n;
    logic [15:0] sh_low, sh_low_n;
    logic [15:0] sh_count, sh_count_n;
    logic        inv, inv_n;
    logic        pin, pin_n;
    logic        busy, busy_n;
    logic        done, done_n;
    logic        inv_in;
    logic [15:0] hi_in, lo_in, cnt_in;

    assign hi_in  = high_time[ch*16 +: 16];
    assign lo_in  = low_time[ch*16 +: 16];
    assign cnt_in = pulse_count[ch*16 +: 16];
`ifdef SIGGEN_INVERT_EN
    assign inv_in = gen_invert[ch];
`else
    assign inv_in = 1'b0;
`endif

    always_comb begin
      state_n    = state;
      phase_n    = phase;
      periods_n  = periods;
      sh_high_n  = sh_high;
      sh_low_n   = sh_low;
      sh_count_n = sh_count;
      inv_n      = inv;
      done_n     = 1'b0;
      unique case (state)
        IDLE: begin
          if (gen_start[ch] && !gen_stop[ch] &&
              hi_in != 16'd0 && lo_in != 16'd0) begin
            state_n    = HIGH;
            phase_n    = 16'd1;
            periods_n  = 16'd0;
            sh_high_n  = hi_in;
            sh_low_n   = lo_in;
            sh_count_n = cnt_in;
            inv_n      = inv_in;
          end
        end
        HIGH: begin
          if (gen_stop[ch]) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (phase == sh_high) begin
            state_n = LOW;
            phase_n = 16'd1;
          end else begin
            phase_n = phase + 16'd1;
          end
        end
        LOW: begin
          if (gen_stop[ch]) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (phase == sh_low) begin
            // period counter wraps freely in continuous mode
            periods_n = periods + 16'd1;
            phase_n   = 16'd1;
            if (sh_count != 16'd0 && periods_n == sh_count) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = HIGH;
            end
          end else begin
            phase_n = phase + 16'd1;
          end
        end
        default: state_n = IDLE;
      endcase
      pin_n  = (state_n == HIGH) ^ inv_n;
      busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= IDLE;
        phase    <= 16'd0;
        periods  <= 16'd0;
        sh_high  <= 16'd0;
        sh_low   <= 16'd0;
        sh_count <= 16'd0;
        inv      <= 1'b0;
        pin      <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b0;
      end else begin
        state    <= state_n;
        phase    <= phase_n;
        periods  <= periods_n;
        sh_high  <= sh_high_n;
        sh_low   <= sh_low_n;
        sh_count <= sh_count_n;
        inv      <= inv_n;
        pin      <= pin_n;
        busy     <= busy_n;
        done     <= done_n;
      end
    end

    assign gen_pin[ch]  = pin;
    assign gen_busy[ch] = busy;
    assign gen_done[ch] = done;
  end

endmodule

// File: tb/tb_signal_gen_multichannel.sv
// Scoreboard bench for signal_gen_multichannel with an arithmetic timeline model.
// Define SIGGEN_INVERT_EN to exercise the inverted-polarity build.
module tb_signal_gen_multichannel;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   gen_start, gen_stop;
  logic [N*16-1:0] high_time, low_time, pulse_count;
  logic [N-1:0]   gen_pin, gen_busy, gen_done;
`ifdef SIGGEN_INVERT_EN
  logic [N-1:0]   gen_invert;
`endif

  signal_gen_multichannel #(.NUM_CHANNELS(N)) dut (
    .clk(clk),
    .rst(rst),
    .gen_start(gen_start),
    .gen_stop(gen_stop),
    .high_time(high_time),
    .low_time(low_time),
    .pulse_count(pulse_count),
`ifdef SIGGEN_INVERT_EN
    .gen_invert(gen_invert),
`endif
    .gen_pin(gen_pin),
    .gen_busy(gen_busy),
    .gen_done(gen_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] pin;
    logic [N-1:0] busy;
    logic [N-1:0] done;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     w;

  bit     run[N];
  longint s0[N], mh[N], ml[N], mc[N];
  bit     mi[N];

  task automatic set_ch(input int ch, input int h, input int l, input int c);
    high_time[ch*16 +: 16]   = 16'(h);
    low_time[ch*16 +: 16]    = 16'(l);
    pulse_count[ch*16 +: 16] = 16'(c);
  endtask

  // Called at negedge with inputs set; predicts outputs after the next edge.
  task automatic step(input logic r);
    exp_t   e;
    longint h, l, p, k;
    e = '0;
    rst = r;
    for (int ch = 0; ch < N; ch++) begin
      h = longint'(high_time[ch*16 +: 16]);
      l = longint'(low_time[ch*16 +: 16]);
      if (r) begin
        run[ch] = 0;
        mi[ch]  = 0;
      end else if (run[ch]) begin
        p = mh[ch] + ml[ch];
        k = cyc - s0[ch];
        if ((mc[ch] != 0 && k == mc[ch] * p) || gen_stop[ch]) begin
          run[ch]    = 0;
          e.done[ch] = 1'b1;
        end else begin
          e.busy[ch] = 1'b1;
          e.pin[ch]  = ((k % p) < mh[ch]);
        end
      end else if (gen_start[ch] && !gen_stop[ch] && h != 0 && l != 0) begin
        run[ch] = 1;
        s0[ch]  = cyc;
        mh[ch]  = h;
        ml[ch]  = l;
        mc[ch]  = longint'(pulse_count[ch*16 +: 16]);
`ifdef SIGGEN_INVERT_EN
        mi[ch]  = gen_invert[ch];
`endif
        e.busy[ch] = 1'b1;
        e.pin[ch]  = 1'b1;
      end
      e.pin[ch] = e.pin[ch] ^ mi[ch];
    end
    q.push_back(e);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({gen_pin, gen_busy, gen_done} !== e) begin
          errors++;
          $display("FAIL cyc%0d pin %b want %b busy %b want %b done %b want %b",
                   cyc, gen_pin, e.pin, gen_busy, e.busy, gen_done, e.done);
        end
      end
    end
  end

  initial begin : stim
    for (int ch = 0; ch < N; ch++) begin
      run[ch] = 0;
      mi[ch]  = 0;
      s0[ch]  = 0;
      mh[ch]  = 1;
      ml[ch]  = 1;
      mc[ch]  = 0;
    end
    rst = 1'b1;
    gen_start = '0;
    gen_stop = '0;
    high_time = '0;
    low_time = '0;
    pulse_count = '0;
`ifdef SIGGEN_INVERT_EN
    gen_invert = '0;
`endif
    @(negedge clk);
    step(1'b1);
    step(1'b1);
    checks++;
    if ({gen_pin, gen_busy, gen_done} !== '0) begin
      errors++;
      $display("FAIL reset state pin %b busy %b done %b",
               gen_pin, gen_busy, gen_done);
    end

    set_ch(0, 3, 2, 2);
    gen_start[0] = 1'b1;
    step(1'b0);
    gen_start = '0;
    w = 0;
    while (gen_done[0] !== 1'b1 && w < 20) begin
      step(1'b0);
      w++;
    end
    checks++;
    if (gen_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL timeout waiting for ch0 gen_done");
    end
    repeat (3) step(1'b0);

    set_ch(3, 1, 1, 0);
    gen_start[3] = 1'b1;
    step(1'b0);
    gen_start = '0;
    repeat (100) step(1'b0);
    gen_stop[3] = 1'b1;
    step(1'b0);
    gen_stop = '0;
    repeat (3) step(1'b0);

    set_ch(1, 0, 5, 0);
    gen_start[1] = 1'b1;
    step(1'b0);
    gen_start = '0;
    repeat (5) step(1'b0);
    set_ch(1, 4, 4, 2);
    gen_start[1] = 1'b1;
    step(1'b0);
    gen_start = '0;
    repeat (20) step(1'b0);

    for (int ch = 0; ch < N; ch++) set_ch(ch, ch*2+1, ch+1, 3);
    gen_start = '1;
    step(1'b0);
    gen_start = '0;
    repeat (75) step(1'b0);

    set_ch(2, 10, 10, 0);
    gen_start[2] = 1'b1;
    step(1'b0);
    gen_start = '0;
    repeat (4) step(1'b0);
    set_ch(2, 3, 10, 0);
    gen_start[2] = 1'b1;
    repeat (20) step(1'b0);
    gen_start = '0;
    step(1'b1);
    step(1'b0);
    set_ch(2, 3, 2, 2);
    gen_start[2] = 1'b1;
    step(1'b0);
    gen_start = '0;
    repeat (15) step(1'b0);

`ifdef SIGGEN_INVERT_EN
    gen_invert[0] = 1'b1;
    set_ch(0, 2, 3, 1);
    gen_start[0] = 1'b1;
    step(1'b0);
    gen_start = '0;
    gen_invert = '0;
    repeat (10) step(1'b0);
`endif

    repeat (2000) begin
      for (int ch = 0; ch < N; ch++) begin
        gen_start[ch] = ($urandom_range(7) == 0);
        gen_stop[ch]  = ($urandom_range(39) == 0);
        set_ch(ch, $urandom_range(5), $urandom_range(5), $urandom_range(4));
`ifdef SIGGEN_INVERT_EN
        gen_invert[ch] = 1'($urandom_range(1));
`endif
      end
      step(($urandom_range(299) == 0) ? 1'b1 : 1'b0);
    end
    gen_start = '0;
    gen_stop = '0;
    repeat (3) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
